// File: rtl/display_mux_scheduler.sv
// Dual-digit seven-segment scan controller: per-frame digit latch, blank/dwell sequencing, frame pulse.
// Optional per-frame brightness control when DISPLAY_PWM_EN is defined (adds the duty port).
module display_mux_scheduler #(
    parameter int unsigned DWELL_CYCLES = 48000,
    parameter int unsigned BLANK_CYCLES = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
`ifdef DISPLAY_PWM_EN
    input  logic [3:0] duty,
`endif
    output logic [3:0] nibble,
    output logic       an0_n,
    output logic       an1_n,
    output logic       frame
);

    localparam int unsigned MAX_CYC    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYC + 1);
    localparam int unsigned DWELL_LAST = (DWELL_CYCLES == 0) ? 0 : DWELL_CYCLES - 1;
    localparam int unsigned BLANK_LAST = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
    localparam bit          HAS_BLANK  = (BLANK_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BLANK0 = 3'd1,
        SHOW0  = 3'd2,
        BLANK1 = 3'd3,
        SHOW1  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      s1_q, s1_d;
    logic [3:0]      s2_q, s2_d;
    logic [3:0]      nibble_d;
    logic            an0_n_d, an1_n_d, frame_d;
    logic            frame_load;
    logic            lit_c;
    logic            blank_done, dwell_done;
`ifdef DISPLAY_PWM_EN
    logic [3:0]      duty_q, duty_d;
`endif

    assign blank_done = (cnt_q == CW'(BLANK_LAST));
    assign dwell_done = (cnt_q == CW'(DWELL_LAST));

    // A new frame starts from IDLE or at the end of the second digit's dwell
    assign frame_load = en && ((state_q == IDLE) || ((state_q == SHOW1) && dwell_done));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and dwell/blank counter
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE:    state_d = HAS_BLANK ? BLANK0 : SHOW0;
            BLANK0:  if (blank_done) state_d = SHOW0;
            SHOW0:   if (dwell_done) state_d = HAS_BLANK ? BLANK1 : SHOW1;
            BLANK1:  if (blank_done) state_d = SHOW1;
            SHOW1:   if (dwell_done) state_d = HAS_BLANK ? BLANK0 : SHOW0;
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d = IDLE;
        end
        if ((state_d == state_q) && (state_d != IDLE)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Output and latch next values, all derived from the upcoming state
    always_comb begin
        s1_d     = s1_q;
        s2_d     = s2_q;
        nibble_d = nibble;
        frame_d  = frame_load;
`ifdef DISPLAY_PWM_EN
        duty_d   = duty_q;
`endif
        if (frame_load) begin
            s1_d = s1;
            s2_d = s2;
`ifdef DISPLAY_PWM_EN
            duty_d = duty;
`endif
        end

        unique case (state_d)
            BLANK0, SHOW0: nibble_d = frame_load ? s1 : s1_q;
            BLANK1, SHOW1: nibble_d = s2_q;
            default:       nibble_d = nibble;
        endcase

`ifdef DISPLAY_PWM_EN
        lit_c = ((32'(cnt_d) * 32'd15) < (32'(duty_d) * 32'(DWELL_CYCLES)));
`else
        lit_c = 1'b1;
`endif
        an0_n_d = !((state_d == SHOW0) && lit_c);
        an1_n_d = !((state_d == SHOW1) && lit_c);
    end

    // Counter, latched digits and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            nibble <= '0;
            an0_n  <= 1'b1;
            an1_n  <= 1'b1;
            frame  <= 1'b0;
`ifdef DISPLAY_PWM_EN
            duty_q <= '0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            nibble <= nibble_d;
            an0_n  <= an0_n_d;
            an1_n  <= an1_n_d;
            frame  <= frame_d;
`ifdef DISPLAY_PWM_EN
            duty_q <= duty_d;
`endif
        end
    end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Directed scoreboard bench for display_mux_scheduler; two instances (with and without blanking).
// Exercises DISPLAY_PWM_EN brightness when that macro is defined.
module tb_display_mux_scheduler;

    localparam int unsigned DA = 8;
    localparam int unsigned BA = 2;
    localparam int unsigned DB = 4;
    localparam int unsigned BB = 0;
`ifdef DISPLAY_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en_a, en_b;
    logic [3:0] s1, s2;
    logic [3:0] duty_a, duty_b;
    logic [3:0] nib_a, nib_b;
    logic       an0_a, an1_a, fr_a;
    logic       an0_b, an1_b, fr_b;

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle outputs: {frame, an0_n, an1_n, nibble}
    logic [6:0] q_a[$];
    logic [6:0] q_b[$];

    always #5 clk = ~clk;

    display_mux_scheduler #(.DWELL_CYCLES(DA), .BLANK_CYCLES(BA)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .s1(s1), .s2(s2),
`ifdef DISPLAY_PWM_EN
        .duty(duty_a),
`endif
        .nibble(nib_a), .an0_n(an0_a), .an1_n(an1_a), .frame(fr_a)
    );

    display_mux_scheduler #(.DWELL_CYCLES(DB), .BLANK_CYCLES(BB)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .s1(s1), .s2(s2),
`ifdef DISPLAY_PWM_EN
        .duty(duty_b),
`endif
        .nibble(nib_b), .an0_n(an0_b), .an1_n(an1_b), .frame(fr_b)
    );

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Push the first ncyc cycles of a frame showing digits a then b
    task automatic push_frame(input bit sel_b, input int unsigned b_cyc, input int unsigned d_cyc,
                              input logic [3:0] a, input logic [3:0] b,
                              input int unsigned duty, input int unsigned ncyc);
        int unsigned n;
        int unsigned len;
        bit          lit;
        logic [3:0]  v;
        logic [6:0]  e;
        n = 0;
        for (int ph = 0; ph < 4; ph++) begin
            len = (ph % 2 == 0) ? b_cyc : d_cyc;
            v   = (ph < 2) ? a : b;
            for (int unsigned i = 0; i < len; i++) begin
                lit = !PWM || ((i * 15) < (duty * d_cyc));
                e   = {(n == 0), !(ph == 1 && lit), !(ph == 3 && lit), v};
                if (n < ncyc) begin
                    if (sel_b) q_b.push_back(e);
                    else       q_a.push_back(e);
                end
                n++;
            end
        end
    endtask

    task automatic push_one(input bit sel_b, input logic [6:0] e);
        if (sel_b) q_b.push_back(e);
        else       q_a.push_back(e);
    endtask

    // Advance n cycles, comparing each sampled output against the scoreboard
    task automatic run(input bit sel_b, input int n, input string tag);
        logic [6:0] obs;
        logic [6:0] exp_v;
        int         sz;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            obs = sel_b ? {fr_b, an0_b, an1_b, nib_b} : {fr_a, an0_a, an1_a, nib_a};
            sz  = sel_b ? q_b.size() : q_a.size();
            checks++;
            assert (sz > 0) else begin
                failures++;
                $error("FAIL %s_underflow cyc=%0d observed=%b expected=queued", tag, i, obs);
            end
            if (sz > 0) begin
                exp_v = sel_b ? q_b.pop_front() : q_a.pop_front();
                checks++;
                assert (obs === exp_v) else begin
                    failures++;
                    $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, i, obs, exp_v);
                end
                checks++;
                assert (obs[5] || obs[4]) else begin
                    failures++;
                    $error("FAIL %s_both_on cyc=%0d observed=%b expected=one_enable_max", tag, i, obs);
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        en_a   = 1'b0;
        en_b   = 1'b0;
        s1     = 4'h3;
        s2     = 4'hA;
        duty_a = 4'd15;
        duty_b = 4'd15;

        repeat (2) @(posedge clk);
        #1;
        check("reset_a", {fr_a, an0_a, an1_a, nib_a}, 7'b0110000);
        check("reset_b", {fr_b, an0_b, an1_b, nib_b}, 7'b0110000);
        reset = 1'b1;

        // No blanking: digits alternate every DB cycles, frame every 2*DB
        en_b = 1'b1;
        push_frame(1'b1, BB, DB, 4'h3, 4'hA, 15, 2 * DB);
        push_frame(1'b1, BB, DB, 4'h3, 4'hA, 15, 2 * DB);
        run(1'b1, 4 * DB, "noblank");
        en_b = 1'b0;

        // Basic scan, then an s1 change during SHOW0 shows only from the next frame
        en_a = 1'b1;
        push_frame(1'b0, BA, DA, 4'h3, 4'hA, 15, 2 * (BA + DA));
        push_frame(1'b0, BA, DA, 4'h7, 4'hA, 15, 2 * (BA + DA));
        run(1'b0, 5, "scan");
        s1 = 4'h7;
        run(1'b0, 4 * (BA + DA) - 5, "coherent");

        // en dropped for one cycle during SHOW1
        push_frame(1'b0, BA, DA, 4'h7, 4'hA, 15, 14);
        run(1'b0, 14, "pre_drop");
        en_a = 1'b0;
        push_one(1'b0, 7'b0111010);
        run(1'b0, 1, "idle");
        en_a = 1'b1;
        s2   = 4'h5;
        push_frame(1'b0, BA, DA, 4'h7, 4'h5, 15, 2 * (BA + DA));
        run(1'b0, 2 * (BA + DA), "restart");

        // Brightness settings (full dwell in builds without PWM)
        duty_a = 4'd8;
        push_frame(1'b0, BA, DA, 4'h7, 4'h5, 8, 2 * (BA + DA));
        run(1'b0, 2 * (BA + DA), "duty8");
        duty_a = 4'd0;
        push_frame(1'b0, BA, DA, 4'h7, 4'h5, 0, 2 * (BA + DA));
        run(1'b0, 2 * (BA + DA), "duty0");
        duty_a = 4'd15;

        // Asynchronous reset during SHOW0
        push_frame(1'b0, BA, DA, 4'h7, 4'h5, 15, 5);
        run(1'b0, 5, "pre_reset");
        reset = 1'b0;
        #1;
        check("async_reset", {fr_a, an0_a, an1_a, nib_a}, 7'b0110000);
        @(posedge clk);
        #1;
        check("reset_hold", {fr_a, an0_a, an1_a, nib_a}, 7'b0110000);
        reset = 1'b1;
        push_frame(1'b0, BA, DA, 4'h7, 4'h5, 15, 2 * (BA + DA));
        run(1'b0, 2 * (BA + DA), "post_reset");

        checks++;
        assert ((q_a.size() == 0) && (q_b.size() == 0)) else begin
            failures++;
            $error("FAIL drain observed=%0d/%0d expected=0/0", q_a.size(), q_b.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
